// File: rtl/uart_pkg.sv
// Shared types and register offsets for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam logic [1:0] UART_OFS_TXDATA = 2'd0;
    localparam logic [1:0] UART_OFS_STATUS = 2'd1;

    // STATUS layout: [0] full, [1] empty, [2] busy, [3] ovf, [15:8] FIFO count.
    function automatic logic [31:0] pack_status(
        input logic       full,
        input logic       empty,
        input logic       busy,
        input logic       ovf,
        input logic [7:0] count
    );
        return {16'd0, count, 4'd0, ovf, busy, empty, full};
    endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// CPU data-bus bundle as seen by a memory-mapped peripheral.
interface uart_tx_mmio_if;
    logic [31:0] addr;
    logic        we;
    logic        re;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, we, re, wdata, input rdata);
    modport slave  (input addr, we, re, wdata, output rdata);
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus decode, STATUS/overflow, TX FIFO and serialiser FSM.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [3:0]  BASE_NIBBLE  = 4'h2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] dbus_cmd_addr_i,
    input  logic        dbus_cmd_we_i,
    input  logic        dbus_cmd_re_i,
    input  logic [31:0] dbus_write_data_i,
    output logic [31:0] dbus_read_data_o,
    output logic        txd_o
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    uart_state_e  state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          sel, wr_tx, rd_status, baud_last, pop;
    logic [1:0]    ofs;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;
    logic          unused_bits;

    assign sel       = (dbus_cmd_addr_i[31:28] == BASE_NIBBLE);
    assign ofs       = dbus_cmd_addr_i[3:2];
    assign wr_tx     = dbus_cmd_we_i && sel && (ofs == UART_OFS_TXDATA);
    assign rd_status = dbus_cmd_re_i && sel && (ofs == UART_OFS_STATUS);
    assign baud_last = (baud_q == BAUD_MAX);

    assign unused_bits = ^{dbus_cmd_addr_i[27:4], dbus_cmd_addr_i[1:0], dbus_write_data_i[31:8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (wr_tx),
        .pop_i   (pop),
        .din_i   (dbus_write_data_i[7:0]),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign status = pack_status(fifo_full, fifo_empty, (state_q != IDLE), ovf_q, 8'(fifo_count));

    // A byte arriving while full is only lost if the serialiser is not popping this cycle.
    always_comb begin
        ovf_d   = ovf_q;
        rdata_d = '0;
        if (rd_status) begin
            rdata_d = status;
            ovf_d   = 1'b0;
        end
        if (wr_tx && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        txd_d   = 1'b1;
        baud_d  = (state_q == IDLE || baud_last) ? '0 : baud_q + BW'(1);
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    state_d = START;
                end
            end
            START: begin
                txd_d = 1'b0;
                if (baud_last) begin
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                txd_d = shift_q[0];
                if (baud_last) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                // Chain straight into the next start bit so queued bytes leave without a gap.
                if (baud_last) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
        end
    end

    assign txd_o            = txd_q;
    assign dbus_read_data_o = rdata_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx_mmio;
    localparam int CPB = 4;
    localparam logic [31:0] A_TX = 32'h2000_0000;
    localparam logic [31:0] A_ST = 32'h2000_0004;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic txd;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    uart_tx_mmio_if bus();

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_mmio #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4),
        .BASE_NIBBLE  (4'h2)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .dbus_cmd_addr_i   (bus.addr),
        .dbus_cmd_we_i     (bus.we),
        .dbus_cmd_re_i     (bus.re),
        .dbus_write_data_i (bus.wdata),
        .dbus_read_data_o  (bus.rdata),
        .txd_o             (txd)
    );

    // Push edge of a write issued here is returned in n.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, output int n);
        @(negedge clk);
        bus.addr = a; bus.wdata = d; bus.we = 1'b1; bus.re = 1'b0;
        n = cyc + 1;
    endtask

    task automatic idle_bus();
        @(negedge clk);
        bus.we = 1'b0; bus.re = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.addr = a; bus.we = 1'b0; bus.re = 1'b1;
        @(negedge clk);
        bus.re = 1'b0;
        d = bus.rdata;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int n, m;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL rst_txd got=%b want=1", txd); end
        total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=00000000", bus.rdata); end
        rst_n = 1'b1;
        wr(A_TX, 32'h00, n);
        wr(A_TX, 32'h11, m);
        wr(A_TX, 32'h22, m);
        idle_bus();
        wait_cyc(n + 10);
        total++; if (txd !== 1'b0) begin bad++; $display("FAIL rst_preframe got=%b want=0", txd); end
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL rst_mid_txd got=%b want=1", txd); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++; if (txd !== 1'b1) begin bad++; $display("FAIL rst_quiet i=%0d got=%b want=1", i, txd); end
        end
        rd(A_ST, d);
        $display("reset: status=%h", d);
        total++; if (d !== 32'h0000_0002) begin bad++; $display("FAIL rst_status got=%h want=00000002", d); end
    endtask

    task automatic test_single_byte();
        logic [9:0] fr;
        logic [31:0] d;
        int n;
        fr = {1'b1, 8'h55, 1'b0};
        wr(A_TX, 32'h55, n);
        idle_bus();
        wait_cyc(n + 1);
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL sb_pre got=%b want=1", txd); end
        for (int p = 0; p < 10; p++) begin
            for (int j = 0; j < CPB; j++) begin
                wait_cyc(n + 2 + CPB * p + j);
                total++;
                if (txd !== fr[p]) begin
                    bad++; $display("FAIL sb_bit p=%0d j=%0d got=%b want=%b", p, j, txd, fr[p]);
                end
            end
        end
        wait_cyc(n + 42);
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL sb_post got=%b want=1", txd); end
        rd(A_ST, d);
        $display("single byte 0x55: status=%h", d);
        total++; if (d !== 32'h0000_0002) begin bad++; $display("FAIL sb_status got=%h want=00000002", d); end
    endtask

    task automatic test_back_to_back();
        logic [19:0] fr;
        int n, m, idx;
        fr = {1'b1, 8'h42, 1'b0, 1'b1, 8'h41, 1'b0};
        wr(A_TX, 32'h41, n);
        wr(A_TX, 32'h42, m);
        @(negedge clk);
        bus.we = 1'b0; bus.addr = A_ST; bus.re = 1'b1;
        for (int e = n + 2; e < n + 82; e++) begin
            wait_cyc(e);
            idx = (e - n - 2) / CPB;
            total++;
            if (txd !== fr[idx]) begin
                bad++; $display("FAIL b2b_bit e=%0d got=%b want=%b", e - n, txd, fr[idx]);
            end
            total++;
            if (bus.rdata[2] !== 1'b1) begin
                bad++; $display("FAIL b2b_busy e=%0d got=%b want=1", e - n, bus.rdata[2]);
            end
        end
        wait_cyc(n + 82);
        total++; if (bus.rdata[2] !== 1'b0) begin bad++; $display("FAIL b2b_busy_end got=%b want=0", bus.rdata[2]); end
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b want=1", txd); end
        bus.re = 1'b0;
        $display("back-to-back 0x41,0x42: 80 cycles checked");
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        int n, m;
        wr(A_TX, 32'h01, n);
        for (int i = 2; i <= 6; i++) wr(A_TX, 32'(i), m);
        rd(A_ST, d);
        $display("overflow: status=%h", d);
        total++; if (d !== 32'h0000_040D) begin bad++; $display("FAIL ovf_status got=%h want=0000040d", d); end
        rd(A_ST, d);
        $display("overflow reread: status=%h", d);
        total++; if (d !== 32'h0000_0405) begin bad++; $display("FAIL ovf_clear got=%h want=00000405", d); end
        wait_cyc(n + 205);
        rd(A_ST, d);
        $display("overflow drained: status=%h", d);
        total++; if (d !== 32'h0000_0002) begin bad++; $display("FAIL ovf_drain got=%h want=00000002", d); end
    endtask

    task automatic test_push_on_pop();
        logic [31:0] d;
        int n, m;
        wr(A_TX, 32'h10, n);
        for (int i = 1; i <= 4; i++) wr(A_TX, 32'h10 + 32'(i), m);
        idle_bus();
        wait_cyc(n + 19);
        rd(A_ST, d);
        total++; if (d !== 32'h0000_0405) begin bad++; $display("FAIL pop_full got=%h want=00000405", d); end
        wait_cyc(n + 39);
        wr(A_TX, 32'hA5, m);
        total++; if (m !== n + 41) begin bad++; $display("FAIL pop_align got=%0d want=%0d", m - n, 41); end
        rd(A_ST, d);
        $display("push on pop: status=%h", d);
        total++; if (d !== 32'h0000_0405) begin bad++; $display("FAIL pop_status got=%h want=00000405", d); end
        wait_cyc(n + 245);
        rd(A_ST, d);
        total++; if (d !== 32'h0000_0002) begin bad++; $display("FAIL pop_drain got=%h want=00000002", d); end
    endtask

    task automatic test_decode();
        int n;
        wr(32'h3000_0000, 32'h77, n);
        wr(32'h2000_0008, 32'h77, n);
        idle_bus();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++; if (txd !== 1'b1) begin bad++; $display("FAIL dec_txd i=%0d got=%b want=1", i, txd); end
        end
        @(negedge clk);
        bus.addr = A_ST; bus.re = 1'b1;
        @(negedge clk);
        total++; if (bus.rdata !== 32'h0000_0002) begin bad++; $display("FAIL dec_status got=%h want=00000002", bus.rdata); end
        bus.addr = 32'h2000_000C;
        @(negedge clk);
        total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL dec_ofs3 got=%h want=00000000", bus.rdata); end
        bus.addr = A_ST;
        @(negedge clk);
        total++; if (bus.rdata !== 32'h0000_0002) begin bad++; $display("FAIL dec_status2 got=%h want=00000002", bus.rdata); end
        bus.addr = 32'h3000_0004;
        @(negedge clk);
        total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL dec_base got=%h want=00000000", bus.rdata); end
        bus.re = 1'b0;
        $display("decode: foreign base and offset 2/3 ignored");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d limit reached", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bus.addr = '0; bus.we = 1'b0; bus.re = 1'b0; bus.wdata = '0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_push_on_pop();
        test_decode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
